// File: rtl/s_cpu_pkg.sv
// Shared SPC700 CPU types: bit-instruction sequencer ops/states and 1-bit ALU controls.
package s_cpu_pkg;

  localparam int unsigned SB_ADDR_W = 13;
  localparam int unsigned SB_BIT_W  = 3;

  typedef enum logic [2:0] {
    SB_OP_AND1    = 3'd0,
    SB_OP_AND1N   = 3'd1,
    SB_OP_OR1     = 3'd2,
    SB_OP_OR1N    = 3'd3,
    SB_OP_EOR1    = 3'd4,
    SB_OP_NOT1    = 3'd5,
    SB_OP_MOV1_LD = 3'd6,
    SB_OP_MOV1_ST = 3'd7
  } bitseq_op_type;

  typedef enum logic [2:0] {
    SB_ST_IDLE     = 3'd0,
    SB_ST_FETCH_LO = 3'd1,
    SB_ST_FETCH_HI = 3'd2,
    SB_ST_READ     = 3'd3,
    SB_ST_DUMMY    = 3'd4,
    SB_ST_WRITE    = 3'd5
  } bitseq_state_type;

  typedef enum logic [2:0] {
    BA_AND1_C   = 3'd0,
    BA_AND1_N_C = 3'd1,
    BA_OR1_C    = 3'd2,
    BA_OR1_N_C  = 3'd3,
    BA_EOR1_C   = 3'd4,
    BA_NOT1     = 3'd5,
    BA_MOV1_C   = 3'd6
  } bitalu_op_type;

  function automatic bitalu_op_type sb_alu_ctrl(input bitseq_op_type op);
    bitalu_op_type ctrl;
    case (op)
      SB_OP_AND1:    ctrl = BA_AND1_C;
      SB_OP_AND1N:   ctrl = BA_AND1_N_C;
      SB_OP_OR1:     ctrl = BA_OR1_C;
      SB_OP_OR1N:    ctrl = BA_OR1_N_C;
      SB_OP_EOR1:    ctrl = BA_EOR1_C;
      SB_OP_NOT1:    ctrl = BA_NOT1;
      default:       ctrl = BA_MOV1_C;
    endcase
    return ctrl;
  endfunction

  // NOT1 and MOV1 mem.bit,C modify memory only; every other op updates C.
  function automatic logic sb_writes_carry(input bitseq_op_type op);
    return !((op == SB_OP_NOT1) || (op == SB_OP_MOV1_ST));
  endfunction

endpackage

// File: rtl/s_bitalu.sv
// 1-bit ALU for SPC700 bit instructions: combines carry with a[b] or rewrites bit b of a.
module s_bitalu
  import s_cpu_pkg::*;
(
  input  bitalu_op_type ctrl,
  input  logic [7:0]    a,
  input  logic [2:0]    b,
  input  logic          c,
  output logic [7:0]    y,
  output logic          cout
);

  logic bit_val;

  assign bit_val = a[b];

  always_comb begin
    y    = a;
    cout = c;
    case (ctrl)
      BA_AND1_C:   cout = c & bit_val;
      BA_AND1_N_C: cout = c & ~bit_val;
      BA_OR1_C:    cout = c | bit_val;
      BA_OR1_N_C:  cout = c | ~bit_val;
      BA_EOR1_C:   cout = c ^ bit_val;
      BA_NOT1:     y[b] = ~bit_val;
      BA_MOV1_C: begin
        // Load direction uses cout, store direction uses y; both share one control.
        cout = bit_val;
        y[b] = c;
      end
      default: begin
        y    = a;
        cout = c;
      end
    endcase
  end

endmodule

// File: rtl/s_bitseq.sv
// Operand/memory sequencer for SPC700 absolute bit instructions (AND1..MOV1).
// Define S_BITSEQ_DUMMY_CYCLE_EN for the cycle-accurate DUMMY read state.
module s_bitseq
  import s_cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_en,
  input  logic          start,
  input  bitseq_op_type op,
  input  logic          c_in,
  input  logic [15:0]   pc,
  output logic          pc_inc,
  output logic [15:0]   mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          c_out,
  output logic          c_we,
  output logic          busy,
  output logic          done
);

  bitseq_state_type state_q, state_d, after_read;
  bitseq_op_type    op_q;
  logic             c_q;
  logic [SB_ADDR_W-1:0] addr_q;
  logic [SB_BIT_W-1:0]  bit_q;
  logic [7:0]       data_q;
  logic             done_q;
  logic             final_edge;

  logic [7:0]       alu_a;
  logic [7:0]       alu_y;
  logic             alu_cout;

  always_comb begin
    after_read = SB_ST_IDLE;
    case (op_q)
      SB_OP_NOT1: after_read = SB_ST_WRITE;
`ifdef S_BITSEQ_DUMMY_CYCLE_EN
      SB_OP_OR1, SB_OP_OR1N, SB_OP_EOR1, SB_OP_MOV1_ST: after_read = SB_ST_DUMMY;
`else
      SB_OP_MOV1_ST: after_read = SB_ST_WRITE;
`endif
      default: after_read = SB_ST_IDLE;
    endcase
  end

  // IDLE reacts to start without cpu_en; every other state waits for the strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_ST_IDLE:     if (start)  state_d = SB_ST_FETCH_LO;
      SB_ST_FETCH_LO: if (cpu_en) state_d = SB_ST_FETCH_HI;
      SB_ST_FETCH_HI: if (cpu_en) state_d = SB_ST_READ;
      SB_ST_READ:     if (cpu_en) state_d = after_read;
      SB_ST_DUMMY: begin
        if (cpu_en) state_d = (op_q == SB_OP_MOV1_ST) ? SB_ST_WRITE : SB_ST_IDLE;
      end
      SB_ST_WRITE:    if (cpu_en) state_d = SB_ST_IDLE;
      default:        state_d = SB_ST_IDLE;
    endcase
  end

  assign final_edge = (state_q != SB_ST_IDLE) && (state_d == SB_ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SB_ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= final_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= SB_OP_AND1;
      c_q    <= 1'b0;
      addr_q <= '0;
      bit_q  <= '0;
      data_q <= '0;
    end else begin
      if ((state_q == SB_ST_IDLE) && start) begin
        op_q <= op;
        c_q  <= c_in;
      end
      if (cpu_en) begin
        case (state_q)
          SB_ST_FETCH_LO: addr_q[7:0] <= mem_rdata;
          SB_ST_FETCH_HI: begin
            addr_q[SB_ADDR_W-1:8] <= mem_rdata[4:0];
            bit_q                 <= mem_rdata[7:5];
          end
          SB_ST_READ:     data_q <= mem_rdata;
          default: begin
          end
        endcase
      end
    end
  end

  // The ALU sees the byte on the bus during READ so the carry is ready at READ's edge.
  assign alu_a = (state_q == SB_ST_READ) ? mem_rdata : data_q;

  s_bitalu u_bitalu (
    .ctrl (sb_alu_ctrl(op_q)),
    .a    (alu_a),
    .b    (bit_q),
    .c    (c_q),
    .y    (alu_y),
    .cout (alu_cout)
  );

  always_comb begin
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      SB_ST_FETCH_LO, SB_ST_FETCH_HI: begin
        mem_addr = pc;
        mem_rd   = 1'b1;
      end
      SB_ST_READ, SB_ST_DUMMY: begin
        mem_addr = {3'b000, addr_q};
        mem_rd   = 1'b1;
      end
      SB_ST_WRITE: begin
        mem_addr  = {3'b000, addr_q};
        mem_wr    = 1'b1;
        mem_wdata = alu_y;
      end
      default: begin
      end
    endcase
  end

  assign pc_inc = cpu_en && !reset &&
                  ((state_q == SB_ST_FETCH_LO) || (state_q == SB_ST_FETCH_HI));
  assign c_we   = final_edge && !reset && sb_writes_carry(op_q);
  assign c_out  = c_we & alu_cout;
  assign busy   = (state_q != SB_ST_IDLE);
  assign done   = done_q;

endmodule

// File: tb/tb_s_bitseq.sv
// Directed self-checking bench for s_bitseq with a flat 64 KiB memory and a pc model.
module tb_s_bitseq;
  import s_cpu_pkg::*;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          cpu_en = 1'b1;
  logic          start  = 1'b0;
  logic          c_in   = 1'b0;
  bitseq_op_type op     = SB_OP_AND1;
  logic [15:0]   pc_r   = 16'h8000;
  logic          pc_inc, mem_rd, mem_wr, c_out, c_we, busy, done;
  logic [15:0]   mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic [7:0]    mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  int          n_pcinc = 0, n_wr = 0, n_cwe = 0, n_done = 0, n_drd = 0;
  logic [15:0] wr_addr = '0, last_drd = '0;
  logic [7:0]  wr_data = '0;
  logic        last_cout = 1'b0;

  s_bitseq dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_en    (cpu_en),
    .start     (start),
    .op        (op),
    .c_in      (c_in),
    .pc        (pc_r),
    .pc_inc    (pc_inc),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .c_out     (c_out),
    .c_we      (c_we),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) if (pc_inc === 1'b1) pc_r <= pc_r + 16'd1;

  // Operands live at 0x8000 and up, so any read below 0x2000 is a data-byte access.
  always @(negedge clk) begin
    if (pc_inc === 1'b1) n_pcinc <= n_pcinc + 1;
    if (mem_wr === 1'b1 && cpu_en) begin
      n_wr    <= n_wr + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
    if (c_we === 1'b1) begin
      n_cwe     <= n_cwe + 1;
      last_cout <= c_out;
    end
    if (done === 1'b1) n_done <= n_done + 1;
    if (mem_rd === 1'b1 && cpu_en && mem_addr < 16'h2000) begin
      n_drd    <= n_drd + 1;
      last_drd <= mem_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic place(input logic [7:0] lo, input logic [7:0] hi);
    mem[pc_r]         = lo;
    mem[pc_r + 16'd1] = hi;
  endtask

  task automatic run_op(input bitseq_op_type o, input logic c, output int n);
    op    = o;
    c_in  = c;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (c_we !== 1'b0) begin n_fail++; $display("FAIL reset_c_we: got %b want 0", c_we); end
    n_checks++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL reset_c_out: got %b want 0", c_out); end
    n_checks++; if (pc_inc !== 1'b0) begin n_fail++; $display("FAIL reset_pc_inc: got %b want 0", pc_inc); end
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_and1();
    int n, b_pc, b_wr, b_cwe, b_drd;
    mem[16'h0234] = 8'h20;
    place(8'h34, 8'hA2);
    b_pc = n_pcinc; b_wr = n_wr; b_cwe = n_cwe; b_drd = n_drd;
    run_op(SB_OP_AND1, 1'b1, n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL and1_cycles: got %0d want 3", n); end
    n_checks++; if (last_drd !== 16'h0234) begin n_fail++; $display("FAIL and1_rd_addr: got %h want 0234", last_drd); end
    n_checks++; if (n_drd - b_drd !== 1) begin n_fail++; $display("FAIL and1_rd_count: got %0d want 1", n_drd - b_drd); end
    n_checks++; if (n_cwe - b_cwe !== 1) begin n_fail++; $display("FAIL and1_c_we: got %0d want 1", n_cwe - b_cwe); end
    n_checks++; if (last_cout !== 1'b1) begin n_fail++; $display("FAIL and1_c_out: got %b want 1", last_cout); end
    n_checks++; if (n_wr - b_wr !== 0) begin n_fail++; $display("FAIL and1_no_wr: got %0d want 0", n_wr - b_wr); end
    n_checks++; if (n_pcinc - b_pc !== 2) begin n_fail++; $display("FAIL and1_pc_inc: got %0d want 2", n_pcinc - b_pc); end
  endtask

  task automatic test_not1();
    int n, b_wr, b_cwe;
    mem[16'h0234] = 8'h20;
    place(8'h34, 8'hA2);
    b_wr = n_wr; b_cwe = n_cwe;
    run_op(SB_OP_NOT1, 1'b1, n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL not1_cycles: got %0d want 4", n); end
    n_checks++; if (n_wr - b_wr !== 1) begin n_fail++; $display("FAIL not1_wr_count: got %0d want 1", n_wr - b_wr); end
    n_checks++; if (wr_addr !== 16'h0234) begin n_fail++; $display("FAIL not1_wr_addr: got %h want 0234", wr_addr); end
    n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL not1_wr_data: got %h want 00", wr_data); end
    n_checks++; if (n_cwe - b_cwe !== 0) begin n_fail++; $display("FAIL not1_no_c_we: got %0d want 0", n_cwe - b_cwe); end
  endtask

  task automatic test_mov1_st();
    int n, b_wr, b_cwe, b_drd, exp_n, exp_rd;
`ifdef S_BITSEQ_DUMMY_CYCLE_EN
    exp_n = 5; exp_rd = 2;
`else
    exp_n = 4; exp_rd = 1;
`endif
    mem[16'h0234] = 8'h00;
    place(8'h34, 8'hA2);
    b_wr = n_wr; b_cwe = n_cwe; b_drd = n_drd;
    run_op(SB_OP_MOV1_ST, 1'b1, n);
    n_checks++; if (n !== exp_n) begin n_fail++; $display("FAIL mov1st_cycles: got %0d want %0d", n, exp_n); end
    n_checks++; if (n_drd - b_drd !== exp_rd) begin n_fail++; $display("FAIL mov1st_reads: got %0d want %0d", n_drd - b_drd, exp_rd); end
    n_checks++; if (n_wr - b_wr !== 1) begin n_fail++; $display("FAIL mov1st_wr_count: got %0d want 1", n_wr - b_wr); end
    n_checks++; if (wr_addr !== 16'h0234) begin n_fail++; $display("FAIL mov1st_wr_addr: got %h want 0234", wr_addr); end
    n_checks++; if (wr_data !== 8'h20) begin n_fail++; $display("FAIL mov1st_wr_data: got %h want 20", wr_data); end
    n_checks++; if (n_cwe - b_cwe !== 0) begin n_fail++; $display("FAIL mov1st_no_c_we: got %0d want 0", n_cwe - b_cwe); end
  endtask

  typedef struct {
    bitseq_op_type op;
    logic          c;
    logic [7:0]    lo;
    logic [7:0]    hi;
    logic [15:0]   addr;
    logic [7:0]    mval;
    logic          cout;
    int            cyc;
  } vec_t;

  task automatic test_carry_ops();
    vec_t v [5];
    int   n, b_wr, b_cwe, dc;
`ifdef S_BITSEQ_DUMMY_CYCLE_EN
    dc = 4;
`else
    dc = 3;
`endif
    // 0xFF,0x1F -> addr 0x1FFF bit 0; 0x00,0xE0 -> addr 0x0000 bit 7.
    v[0] = '{SB_OP_OR1,     1'b0, 8'hFF, 8'h1F, 16'h1FFF, 8'h01, 1'b1, dc};
    v[1] = '{SB_OP_EOR1,    1'b1, 8'hFF, 8'h1F, 16'h1FFF, 8'h01, 1'b0, dc};
    v[2] = '{SB_OP_MOV1_LD, 1'b1, 8'h00, 8'hE0, 16'h0000, 8'h7F, 1'b0, 3};
    v[3] = '{SB_OP_AND1N,   1'b1, 8'h00, 8'hE0, 16'h0000, 8'h7F, 1'b1, 3};
    v[4] = '{SB_OP_OR1,     1'b0, 8'hFF, 8'h1F, 16'h1FFF, 8'hFE, 1'b0, dc};
    for (int i = 0; i < 5; i++) begin
      mem[v[i].addr] = v[i].mval;
      place(v[i].lo, v[i].hi);
      b_wr = n_wr; b_cwe = n_cwe;
      run_op(v[i].op, v[i].c, n);
      n_checks++; if (n !== v[i].cyc) begin n_fail++; $display("FAIL vec%0d_cycles: got %0d want %0d", i, n, v[i].cyc); end
      n_checks++; if (last_drd !== v[i].addr) begin n_fail++; $display("FAIL vec%0d_rd_addr: got %h want %h", i, last_drd, v[i].addr); end
      n_checks++; if (n_cwe - b_cwe !== 1) begin n_fail++; $display("FAIL vec%0d_c_we: got %0d want 1", i, n_cwe - b_cwe); end
      n_checks++; if (last_cout !== v[i].cout) begin n_fail++; $display("FAIL vec%0d_c_out: got %b want %b", i, last_cout, v[i].cout); end
      n_checks++; if (n_wr - b_wr !== 0) begin n_fail++; $display("FAIL vec%0d_no_wr: got %0d want 0", i, n_wr - b_wr); end
    end
  endtask

  task automatic test_stall();
    int n, b_pc, b_cwe;
    logic [15:0] base;
    mem[16'h0234] = 8'h00;
    place(8'h34, 8'hA2);
    base = pc_r;
    b_pc = n_pcinc; b_cwe = n_cwe;
    op = SB_OP_OR1N; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    cpu_en = 1'b1;
    step();
    cpu_en = 1'b0;
    step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b want 1", busy); end
    n_checks++; if (mem_addr !== base + 16'd1) begin n_fail++; $display("FAIL stall_addr: got %h want %h", mem_addr, base + 16'd1); end
    n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL stall_rd_level: got %b want 1", mem_rd); end
    n_checks++; if (pc_inc !== 1'b0) begin n_fail++; $display("FAIL stall_pc_inc: got %b want 0", pc_inc); end
    step();
    n_checks++; if (mem_addr !== base + 16'd1) begin n_fail++; $display("FAIL stall_addr2: got %h want %h", mem_addr, base + 16'd1); end
    cpu_en = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    step();
    step();
    n_checks++; if (n >= 20) begin n_fail++; $display("FAIL stall_timeout: got %0d cycles want <20", n); end
    n_checks++; if (n_cwe - b_cwe !== 1) begin n_fail++; $display("FAIL stall_c_we: got %0d want 1", n_cwe - b_cwe); end
    n_checks++; if (last_cout !== 1'b1) begin n_fail++; $display("FAIL stall_c_out: got %b want 1", last_cout); end
    n_checks++; if (n_pcinc - b_pc !== 2) begin n_fail++; $display("FAIL stall_pc_inc_count: got %0d want 2", n_pcinc - b_pc); end
  endtask

  task automatic test_reset_mid();
    int n, b_wr, b_cwe, b_done;
    mem[16'h0234] = 8'h20;
    place(8'h34, 8'hA2);
    b_wr = n_wr; b_cwe = n_cwe; b_done = n_done;
    op = SB_OP_NOT1; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rstmid_addr: got %h want 0000", mem_addr); end
    step();
    step();
    step();
    n_checks++; if (n_wr - b_wr !== 0) begin n_fail++; $display("FAIL rstmid_no_wr: got %0d want 0", n_wr - b_wr); end
    n_checks++; if (n_cwe - b_cwe !== 0) begin n_fail++; $display("FAIL rstmid_no_c_we: got %0d want 0", n_cwe - b_cwe); end
    n_checks++; if (n_done - b_done !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", n_done - b_done); end
    mem[16'h0234] = 8'h20;
    place(8'h34, 8'hA2);
    b_cwe = n_cwe;
    run_op(SB_OP_AND1, 1'b1, n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL rstmid_rerun_cycles: got %0d want 3", n); end
    n_checks++; if (n_cwe - b_cwe !== 1 || last_cout !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_rerun_carry: got c_we %0d c_out %b want 1 1", n_cwe - b_cwe, last_cout);
    end
  endtask

  task automatic test_ignored_start();
    int n, b_pc, b_wr, b_done;
    mem[16'h0234] = 8'h20;
    place(8'h34, 8'hA2);
    b_pc = n_pcinc; b_wr = n_wr; b_done = n_done;
    op = SB_OP_AND1; c_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    op = SB_OP_NOT1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    step();
    step();
    step();
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL ign_cycles: got %0d want 3", n); end
    n_checks++; if (n_done - b_done !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", n_done - b_done); end
    n_checks++; if (n_wr - b_wr !== 0) begin n_fail++; $display("FAIL ign_no_wr: got %0d want 0", n_wr - b_wr); end
    n_checks++; if (n_pcinc - b_pc !== 2) begin n_fail++; $display("FAIL ign_pc_inc: got %0d want 2", n_pcinc - b_pc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle: got %b want 0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_and1();
    test_not1();
    test_mov1_st();
    test_carry_ops();
    test_stall();
    test_reset_mid();
    test_ignored_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
